// File: rtl/instr_ping_pong_ctrl_pkg.sv
// Shared types and configuration for the ping-pong instruction memory controller.
package instr_ping_pong_ctrl_pkg;

  localparam int unsigned SRAM_MACRO_WIDTH      = 32;
  localparam int unsigned INSTR_BUF_DEPTH       = 65536;
  localparam int unsigned INSTR_ADDR_L          = $clog2(INSTR_BUF_DEPTH);
  localparam int unsigned INSTR_MEM_RD_LATENCY  = 1;

  typedef logic [SRAM_MACRO_WIDTH-1:0] instr_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } bank_state_t;

endpackage

// File: rtl/instr_ping_pong_ctrl_if.sv
// Loader, SRAM and decoder signals of the ping-pong instruction controller.
interface instr_ping_pong_ctrl_if
  import instr_ping_pong_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W = SRAM_MACRO_WIDTH,
  parameter int unsigned ADDR_L  = INSTR_ADDR_L
);

  logic               ld_valid;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_last;
  logic               ld_ready;

  logic               mem_we;
  logic               mem_wr_bank;
  logic [ADDR_L-1:0]  mem_wr_addr;
  logic [INSTR_W-1:0] mem_wr_data;
  logic               mem_rd_en;
  logic               mem_rd_bank;
  logic [ADDR_L-1:0]  mem_rd_addr;
  logic [INSTR_W-1:0] mem_rd_data;

  logic               exe_req;
  logic               exe_valid;
  logic [INSTR_W-1:0] exe_instr;
  logic               exe_last;
  logic               exe_stall;

  bank_state_t [1:0]  bank_state;

  // Controller view
  modport slave (
    input  ld_valid, ld_data, ld_last, mem_rd_data, exe_req,
    output ld_ready, mem_we, mem_wr_bank, mem_wr_addr, mem_wr_data,
           mem_rd_en, mem_rd_bank, mem_rd_addr,
           exe_valid, exe_instr, exe_last, exe_stall, bank_state
  );

  // Loader / SRAM / decoder view
  modport master (
    output ld_valid, ld_data, ld_last, mem_rd_data, exe_req,
    input  ld_ready, mem_we, mem_wr_bank, mem_wr_addr, mem_wr_data,
           mem_rd_en, mem_rd_bank, mem_rd_addr,
           exe_valid, exe_instr, exe_last, exe_stall, bank_state
  );

endinterface

// File: rtl/instr_bank_fsm.sv
// Per-bank lifecycle EMPTY->FILL->FULL->DRAIN->EMPTY plus the block length latched on close.
module instr_bank_fsm
  import instr_ping_pong_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = INSTR_ADDR_L + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             wr_close,
  input  logic [LEN_W-1:0] close_len,
  input  logic             rd_en,
  input  logic             rd_last,
  output bank_state_t      state,
  output logic [LEN_W-1:0] len
);

  bank_state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      len     <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en && wr_close) len <= close_len;
    end
  end

  // One-word blocks close on their first write and drain on their first read
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (wr_en)    state_d = wr_close ? FULL : FILL;
      FILL:  if (wr_close) state_d = FULL;
      FULL:  if (rd_en)    state_d = rd_last ? EMPTY : DRAIN;
      DRAIN: if (rd_last)  state_d = EMPTY;
      default:             state_d = EMPTY;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/instr_ping_pong_ctrl.sv
// Ping-pong instruction memory controller: loads one bank while the core executes from the other.
module instr_ping_pong_ctrl
  import instr_ping_pong_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W    = SRAM_MACRO_WIDTH,
  parameter int unsigned BUF_DEPTH  = INSTR_BUF_DEPTH,
  parameter int unsigned ADDR_L     = $clog2(BUF_DEPTH),
  parameter int unsigned RD_LATENCY = INSTR_MEM_RD_LATENCY
) (
  input logic                 clk,
  input logic                 rst,
  instr_ping_pong_ctrl_if.slave bus
);

  localparam int unsigned LEN_W = ADDR_L + 1;

  if (RD_LATENCY != 1) begin : g_bad_rd_latency
    $fatal(1, "instr_ping_pong_ctrl: only RD_LATENCY=1 is supported");
  end

  bank_state_t        st  [2];
  logic [LEN_W-1:0]   len [2];
  logic               wr_ptr, rd_ptr;
  logic [ADDR_L-1:0]  wr_cnt, rd_cnt;
  logic               exe_valid_q, exe_last_q;
  logic [INSTR_W-1:0] wr_word_c, rd_word_c;

  logic             ld_ready_c, xfer_c, close_c, rd_ok_c, issue_c, issue_last_c;
  logic [LEN_W-1:0] close_len_c;

  // Load side: accept into the write bank while it is EMPTY or FILL
  assign ld_ready_c  = (st[wr_ptr] == EMPTY) || (st[wr_ptr] == FILL);
  assign xfer_c      = bus.ld_valid && ld_ready_c;
  assign close_c     = xfer_c && (bus.ld_last || (wr_cnt == ADDR_L'(BUF_DEPTH - 1)));
  assign close_len_c = {1'b0, wr_cnt} + LEN_W'(1);

  // Execute side: read from the read bank while it holds a closed block
  assign rd_ok_c      = (st[rd_ptr] == FULL) || (st[rd_ptr] == DRAIN);
  assign issue_c      = bus.exe_req && rd_ok_c;
  assign issue_last_c = issue_c && ({1'b0, rd_cnt} == (len[rd_ptr] - LEN_W'(1)));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    instr_bank_fsm #(.LEN_W(LEN_W)) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (xfer_c && (wr_ptr == 1'(b))),
      .wr_close  (close_c),
      .close_len (close_len_c),
      .rd_en     (issue_c && (rd_ptr == 1'(b))),
      .rd_last   (issue_last_c),
      .state     (st[b]),
      .len       (len[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      exe_valid_q <= 1'b0;
      exe_last_q  <= 1'b0;
    end else begin
      if (close_c) begin
        wr_cnt <= '0;
        wr_ptr <= ~wr_ptr;
      end else if (xfer_c) begin
        wr_cnt <= wr_cnt + ADDR_L'(1);
      end

      if (issue_last_c) begin
        rd_cnt <= '0;
        rd_ptr <= ~rd_ptr;
      end else if (issue_c) begin
        rd_cnt <= rd_cnt + ADDR_L'(1);
      end

      exe_valid_q <= issue_c;
      exe_last_q  <= issue_last_c;
    end
  end

  assign wr_word_c = bus.ld_data;
  assign rd_word_c = bus.mem_rd_data;

  assign bus.ld_ready    = ld_ready_c;
  assign bus.mem_we      = xfer_c;
  assign bus.mem_wr_bank = wr_ptr;
  assign bus.mem_wr_addr = wr_cnt;
  assign bus.mem_wr_data = wr_word_c;
  assign bus.mem_rd_en   = issue_c;
  assign bus.mem_rd_bank = rd_ptr;
  assign bus.mem_rd_addr = rd_cnt;
  assign bus.exe_valid   = exe_valid_q;
  assign bus.exe_instr   = rd_word_c;
  assign bus.exe_last    = exe_last_q;
  assign bus.exe_stall   = bus.exe_req && !rd_ok_c;
  assign bus.bank_state  = {st[1], st[0]};

endmodule

// File: doc/instr_ping_pong_ctrl.md
Name: instr_ping_pong_ctrl

Overview:
- Controls the two halves (bank 0 and bank 1) of the ping-pong instruction memory.
- The loader streams a block of instructions into one bank while the PE-tree core executes from the other bank.
- The controller tracks the state of each bank, generates the SRAM write and read controls, and hands completed blocks to the core in order.
- It sits between the host load interface, the instruction SRAM macros and the instruction decoder.

Parameters:
- INSTR_W, 32 (SRAM_MACRO_WIDTH): instruction word width.
- BUF_DEPTH, 65536: words per bank (INSTR_MEM_SIZE KB split in two).
- ADDR_L, $clog2(BUF_DEPTH): address width within a bank.
- RD_LATENCY, 1 (INSTR_MEM_RD_LATENCY): SRAM read latency. Only 1 is supported; elaboration fails on any other value.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ld_valid  in  1  loader word valid
- ld_data  in  INSTR_W  loader instruction word
- ld_last  in  1  last word of the current block (qualified by ld_valid)
- ld_ready  out  1  controller accepts the word this cycle
- mem_we  out  1  SRAM write enable
- mem_wr_bank  out  1  bank being written
- mem_wr_addr  out  ADDR_L  write address
- mem_wr_data  out  INSTR_W  write data
- mem_rd_en  out  1  SRAM read enable
- mem_rd_bank  out  1  bank being read
- mem_rd_addr  out  ADDR_L  read address
- mem_rd_data  in  INSTR_W  SRAM read data
- exe_req  in  1  core requests the next instruction
- exe_valid  out  1  exe_instr is valid
- exe_instr  out  INSTR_W  instruction to the decoder
- exe_last  out  1  exe_instr is the last word of its block
- exe_stall  out  1  exe_req is pending but no FULL/DRAIN bank exists
- bank_state  out  2x2  per-bank state, for debug and status

Behaviour:
- Each bank has its own state: EMPTY(0), FILL(1), FULL(2), DRAIN(3). Each bank also stores a length register len[b] of width ADDR_L+1.
- Pointers: wr_ptr (next bank to fill) and rd_ptr (next bank to drain). Both reset to 0 and toggle only when a block closes or drains.
- Load side:
  - ld_ready = 1 when bank_state[wr_ptr] is EMPTY or FILL.
  - A transfer happens when ld_valid && ld_ready. The first transfer moves EMPTY->FILL.
  - Each transfer drives mem_we=1, mem_wr_bank=wr_ptr, mem_wr_addr=wr_cnt, mem_wr_data=ld_data, all combinationally in the same cycle. wr_cnt then increments.
  - The block closes on a transfer with ld_last=1, or on the transfer where wr_cnt==BUF_DEPTH-1 (auto-close).
  - On close: len[wr_ptr]=wr_cnt+1, state becomes FULL, wr_cnt resets to 0, wr_ptr toggles.
  - ld_last without ld_valid is ignored.
- Execute side:
  - When bank_state[rd_ptr] is FULL or DRAIN and exe_req=1, the controller issues mem_rd_en=1, mem_rd_bank=rd_ptr, mem_rd_addr=rd_cnt, then increments rd_cnt.
  - The first issue moves FULL->DRAIN.
  - exe_valid is registered and asserts exactly one cycle after each issue. exe_instr = mem_rd_data, passed through.
  - exe_last is registered alongside exe_valid and marks the issue where rd_cnt==len-1.
  - On that last issue: the bank becomes EMPTY, rd_cnt resets to 0, rd_ptr toggles.
- Stall: exe_stall = exe_req && !(bank_state[rd_ptr] in {FULL, DRAIN}). No read is issued while stalled.
- Timing of state changes: all state changes are registered. A bank closed in cycle t can be read from cycle t+1. A bank emptied in cycle t can be filled from cycle t+1.
- Simultaneous fill-close and drain-end on different banks are handled independently in the same cycle.
- A write and a read to the same bank in the same cycle is impossible by construction.
- Reset, including mid-operation: both banks EMPTY, counters 0, pointers 0. Outputs after reset: ld_ready=1, mem_we=0, mem_rd_en=0, exe_valid=0, exe_last=0, exe_stall=0, all addresses 0.

Decomposition:
- Add to hw_config_pkg:
  - typedef instr_t (logic [INSTR_W-1:0])
  - INSTR_BUF_DEPTH
  - INSTR_ADDR_L
  - enum bank_state_t {EMPTY, FILL, FULL, DRAIN}
- Sub-module instr_bank_fsm: one instance per bank. Inputs are start/close/issue/last events; outputs are the state and len.

Test Plan:
1. With BUF_DEPTH=8, load 5 words 0xA0..0xA4 with ld_last on 0xA4 -> bank0 FULL, len=5, wr_ptr=1. Hold exe_req high -> exe_instr A0..A4 on 5 consecutive cycles starting 1 cycle after the first issue; exe_last with A4; bank0 EMPTY.
2. Load 8 words with no ld_last -> auto-close at the 8th word, len=8, ld_ready stays 1 (bank1 EMPTY).
3. Fill bank0 and bank1 (3 words each) with no exe_req -> ld_ready=0. A third block's ld_valid is held and no mem_we occurs until bank0 drains.
4. Concurrency: drain bank0 while loading bank1; bank1 closes in the same cycle bank0 issues its last read -> next cycle the read switches to bank1 with addr 0; no bubble, no lost word.
5. exe_req with both banks EMPTY -> exe_stall=1, mem_rd_en=0. A 1-word block loaded later -> exe_valid exactly once, with exe_last=1.
6. Assert rst mid-drain (2 of 5 words read) -> next cycle both banks EMPTY, exe_valid=0, ld_ready=1. A new block is then read from addr 0 of bank0.
